segment_display_engine: RTL and testbench

- Registered, parametrised seven-segment display engine for the runner game. It replaces the purely combinational display path.
- Drives NUM_DIGITS active-low seven-segment digits from two modes:
  - gameplay mode: ceiling/floor obstacle bits plus the player marker;
  - score mode: a BCD score.
- Converts the binary score with a multi-cycle shift-add-3 engine under a load/busy/ready handshake.
- Adds leading-zero blanking and a blink mode for the game-over screen.
- Sits between game logic (obstacle shifter, score counter, login FSM) and the board's HEX pins.

---
 rtl/segment_display_engine.sv | 202 ++++++++++++++++++++
 tb/tb_segment_display_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_display_engine.sv
// Seven-segment display engine: gameplay view, BCD score view with blanking and blink.
// Latency: disp_o is registered, 1 cycle from the mode/data inputs; a score conversion takes SCORE_W+2 cycles.
// Backpressure: scoreLoad is accepted only while idle; a load seen while busy is dropped, not queued.
module segment_display_engine #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCORE_W      = 14,
  parameter int SCORE_DIGITS = 4,
  parameter int BLINK_DIV    = 25000000,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      logged_in_i,
  input  logic                      show_score_i,
  input  logic                      player_pos_i,
  input  logic [NUM_DIGITS-1:0]     ceiling_bits_i,
  input  logic [NUM_DIGITS-1:0]     floor_bits_i,
  input  logic [SCORE_W-1:0]        score_i,
  input  logic                      score_load_i,
  input  logic                      blink_en_i,
  output logic                      busy_o,
  output logic                      score_ready_o,
  output logic [NUM_DIGITS*7-1:0]   disp_o
);

  localparam int BCD_W = 4 * SCORE_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value the shown digits can hold (all nines); larger scores saturate to it.
  localparam logic [63:0] SAT_MAX = pow10(SCORE_DIGITS) - 64'd1;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_e;

  state_e                  state_q, state_d;
  logic [SCORE_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]        shf_q, shf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic                    ready_q, ready_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    phase_off_q, phase_off_d;
  logic [NUM_DIGITS*7-1:0] disp_q, disp_d;

  logic [63:0]             score_ext;
  logic [SCORE_W-1:0]      score_sat;
  logic [BCD_W-1:0]        adj;
  logic [SCORE_DIGITS-1:0] lz;
  logic                    seen_nz;
  logic [6:0]              dig;

  assign score_ext = {{(64-SCORE_W){1'b0}}, score_i};
  assign score_sat = (score_ext > SAT_MAX) ? SCORE_W'(SAT_MAX) : score_i;

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: IDLE -> CONV on load, CONV for SCORE_W shifts, one LATCH cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (score_load_i) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy covers CONV and LATCH
  always_comb begin
    busy_o        = (state_q != IDLE);
    score_ready_o = ready_q;
    disp_o        = disp_q;
  end

  // Add-3 on every BCD nibble >= 5, ahead of the shift
  always_comb begin
    adj = shf_q;
    for (int k = 0; k < SCORE_DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture, shift-add-3, latch result with a one-cycle ready pulse
  always_comb begin
    bin_d   = bin_q;
    shf_d   = shf_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: if (score_load_i) begin
        bin_d = score_sat;
        shf_d = '0;
        cnt_d = '0;
      end
      CONV: begin
        bin_d = bin_q << 1;
        shf_d = (adj << 1) | BCD_W'(bin_q[SCORE_W-1]);
        cnt_d = cnt_q + CNT_W'(1);
      end
      LATCH: begin
        bcd_d   = shf_q;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Blink timer runs only in score mode with blink enabled; phase toggles on each wrap
  always_comb begin
    blk_cnt_d   = '0;
    phase_off_d = 1'b0;
    if (blink_en_i && show_score_i) begin
      phase_off_d = phase_off_q;
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        phase_off_d = ~phase_off_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  // Leading-zero mask: zero digits above the top non-zero digit; digit 0 always shown
  always_comb begin
    lz      = '0;
    seen_nz = 1'b0;
    for (int k = SCORE_DIGITS - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      lz[k] = LZ_BLANK && !seen_nz && (k != 0);
    end
  end

  // Display mux: logged-out blank, gameplay (obstacle bit 1 lights its segment), score view
  always_comb begin
    disp_d = '1;
    dig    = 7'h7F;
    if (!logged_in_i) begin
      disp_d = '1;
    end else if (!show_score_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = {3'b111, ~floor_bits_i[i], 2'b11, ~ceiling_bits_i[i]};
        if (i == NUM_DIGITS - 2) dig[2:1] = player_pos_i ? 2'b10 : 2'b01;
        disp_d[7*i +: 7] = dig;
      end
    end else if (!(blink_en_i && phase_off_q)) begin
      for (int k = 0; k < SCORE_DIGITS; k++) begin
        disp_d[7*k +: 7] = lz[k] ? 7'h7F : seg(bcd_q[4*k +: 4]);
      end
    end
  end

  // Datapath, blink and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      shf_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      ready_q     <= 1'b0;
      blk_cnt_q   <= '0;
      phase_off_q <= 1'b0;
      disp_q      <= '1;
    end else begin
      bin_q       <= bin_d;
      shf_q       <= shf_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      ready_q     <= ready_d;
      blk_cnt_q   <= blk_cnt_d;
      phase_off_q <= phase_off_d;
      disp_q      <= disp_d;
    end
  end

endmodule

// File: tb/tb_segment_display_engine.sv
// Randomised scoreboard bench for segment_display_engine.
// Expected display / busy / ready are derived from a decimal-arithmetic model of the display.
// A monitor compares every cycle after the active edge; stimulus changes on the falling edge.
module tb_segment_display_engine;

  localparam int ND = 6;
  localparam int SW = 14;
  localparam int SD = 4;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          logged_in, show_score, player_pos, score_load, blink_en;
  logic [ND-1:0] ceil_bits, floor_bits;
  logic [SW-1:0] score;
  logic          busy, score_ready;
  logic [ND*7-1:0] disp;

  always #5 clk = ~clk;

  segment_display_engine #(
    .NUM_DIGITS(ND), .SCORE_W(SW), .SCORE_DIGITS(SD), .BLINK_DIV(BD), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .logged_in_i(logged_in), .show_score_i(show_score),
    .player_pos_i(player_pos), .ceiling_bits_i(ceil_bits), .floor_bits_i(floor_bits),
    .score_i(score), .score_load_i(score_load), .blink_en_i(blink_en),
    .busy_o(busy), .score_ready_o(score_ready), .disp_o(disp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ND*7-1:0] disp_q[$];
  int              conv_q[$];

  // model state
  int cur_val = 0, pend_val = 0, pend_ready = 0, busy_until = -1, blk_j = 0;
  bit pend = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [ND*7-1:0] score_disp(input int v);
    logic [ND*7-1:0] r;
    int p;
    r = '1;
    p = 1;
    for (int k = 0; k < SD; k++) begin
      if (k == 0 || v >= p) r[7*k +: 7] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [ND*7-1:0] game_disp(input logic [ND-1:0] c, input logic [ND-1:0] f,
                                                input logic p);
    logic [ND*7-1:0] r;
    logic [6:0] d;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      d = 7'h7F;
      if (c[i]) d[0] = 1'b0;
      if (f[i]) d[3] = 1'b0;
      if (i == ND - 2) begin
        d[1] = ~p;
        d[2] = p;
      end
      r[7*i +: 7] = d;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [ND*7-1:0] act, input logic [ND*7-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: predict what the next edge must produce, then advance.
  task automatic step();
    int n;
    bit off;
    logic [ND*7-1:0] e;
    n = cyc + 1;
    if (pend && pend_ready <= n - 1) begin
      cur_val = pend_val;
      pend = 0;
    end
    if (blink_en && show_score) begin
      off = ((blk_j / BD) % 2) == 1;
      blk_j++;
    end else begin
      off = 0;
      blk_j = 0;
    end
    if (!logged_in)       e = '1;
    else if (!show_score) e = game_disp(ceil_bits, floor_bits, player_pos);
    else if (off)         e = '1;
    else                  e = score_disp(cur_val);
    disp_q.push_back(e);
    if (score_load && n > busy_until) begin
      pend       = 1;
      pend_val   = (int'(score) > 9999) ? 9999 : int'(score);
      pend_ready = n + SW + 1;
      busy_until = pend_ready;
      conv_q.push_back(pend_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic load(input int v);
    score = SW'(v);
    score_load = 1'b1;
    step();
    score_load = 1'b0;
  endtask

  // Monitor: pops the scoreboard every cycle after the active edge.
  logic [ND*7-1:0] mon_exp;
  logic            mon_busy, mon_rdy;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (disp_q.size() > 0) begin
        mon_exp = disp_q.pop_front();
        chk("disp", disp, mon_exp);
      end
      mon_busy = (conv_q.size() > 0) && (cyc < conv_q[0]);
      mon_rdy  = (conv_q.size() > 0) && (cyc == conv_q[0]);
      checks++;
      if (busy !== mon_busy) begin
        errors++;
        $display("FAIL busy at cycle %0d: got %b expected %b", cyc, busy, mon_busy);
      end
      checks++;
      if (score_ready !== mon_rdy) begin
        errors++;
        $display("FAIL scoreReady at cycle %0d: got %b expected %b", cyc, score_ready, mon_rdy);
      end
      if (mon_rdy) void'(conv_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    logged_in = 0; show_score = 0; player_pos = 0; score_load = 0; blink_en = 0;
    ceil_bits = '0; floor_bits = '0; score = '0;
    #12;
    chk("reset_disp", disp, '1);
    chk("reset_busy", ND*7'(busy), '0);
    chk("reset_ready", ND*7'(score_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    ceil_bits = 6'b101010; floor_bits = 6'b010101;
    steps(3);

    // gameplay view
    logged_in = 1; show_score = 0;
    ceil_bits = 6'b000001; floor_bits = 6'b100000; player_pos = 1;
    step();
    chk("game_d0", ND*7'(disp[6:0]), ND*7'(7'b1111110));
    chk("game_d5", ND*7'(disp[41:35]), ND*7'(7'b1110111));
    chk("game_d4_ceil", ND*7'(disp[34:28]), ND*7'(7'b1111101));
    player_pos = 0;
    step();
    chk("game_d4_floor", ND*7'(disp[34:28]), ND*7'(7'b1111011));

    // conversion of 1234
    show_score = 1;
    load(1234);
    steps(16);
    chk("score_1234", disp, {14'h3FFF, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    // saturation and leading-zero blanking
    load(12000);
    steps(16);
    chk("score_sat", disp, {14'h3FFF, {4{7'b0010000}}});
    load(7);
    steps(16);
    chk("score_7", disp, {{35{1'b1}}, 7'b1111000});

    // second load during busy is dropped
    load(4321);
    steps(4);
    load(1111);
    steps(20);

    // reset mid-conversion aborts it
    load(5555);
    steps(7);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", ND*7'(busy), '0);
    chk("abort_ready", ND*7'(score_ready), '0);
    chk("abort_disp", disp, '1);
    disp_q.delete();
    conv_q.delete();
    cur_val = 0; pend = 0; busy_until = -1; blk_j = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(20);

    // blink
    load(8080);
    steps(17);
    blink_en = 1;
    steps(20);
    blink_en = 0;
    steps(3);

    // randomised traffic
    for (int i = 0; i < 500; i++) begin
      logged_in  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) show_score = ~show_score;
      if ($urandom_range(0, 14) == 0) blink_en = ~blink_en;
      player_pos = 1'($urandom_range(0, 1));
      ceil_bits  = ND'($urandom);
      floor_bits = ND'($urandom);
      case ($urandom_range(0, 2))
        0: score = SW'($urandom_range(0, 9));
        1: score = SW'($urandom_range(0, 9999));
        default: score = SW'($urandom);
      endcase
      score_load = ($urandom_range(0, 7) == 0);
      step();
    end
    score_load = 0;
    steps(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
